// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: FSM states, coin values, credit width.
package vm_pkg;

  localparam int unsigned CREDIT_W = 4;

  localparam logic [CREDIT_W-1:0] SHILLING_VAL = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] FLORIN_VAL   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] CROWN_VAL    = CREDIT_W'(5);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vm_state_t;

endpackage

// File: rtl/change_selector.sv
// Picks the coin to pay out this cycle from the remaining credit and returns
// the credit left afterwards. Define CROWN_CHANGE_EN to pay crowns first.
module change_selector
  import vm_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] credit_next,
  output logic                pay_crown,
  output logic                pay_florin,
  output logic                pay_shilling
);

`ifdef CROWN_CHANGE_EN
  localparam logic CROWN_EN = 1'b1;
`else
  localparam logic CROWN_EN = 1'b0;
`endif

  // Largest coin that still fits in the remaining credit; nothing when empty.
  always_comb begin
    credit_next  = credit;
    pay_crown    = 1'b0;
    pay_florin   = 1'b0;
    pay_shilling = 1'b0;
    if (CROWN_EN && (credit >= CROWN_VAL)) begin
      pay_crown   = 1'b1;
      credit_next = credit - CROWN_VAL;
    end else if (credit >= FLORIN_VAL) begin
      pay_florin  = 1'b1;
      credit_next = credit - FLORIN_VAL;
    end else if (credit == SHILLING_VAL) begin
      pay_shilling = 1'b1;
      credit_next  = credit - SHILLING_VAL;
    end
  end

endmodule

// File: rtl/coin_credit_fsm.sv
// Vending-machine front end: accumulates coin credit, dispenses at PRICE and
// pays change / refunds one coin per cycle. All outputs are registered.
// Optional CROWN_CHANGE_EN (in change_selector) enables crown change.
module coin_credit_fsm
  import vm_pkg::*;
#(
  parameter int unsigned PRICE = 5
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_shilling,
  input  logic       coin_florin,
  input  logic       coin_crown,
  input  logic       cancel,
  output logic [3:0] cState,
  output logic       dispense,
  output logic       florin,
  output logic       florin_c,
  output logic       shilling,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vm_state_t             state_q, state_d;
  logic [CREDIT_W-1:0]   credit_d, sel_next, coin_val;
  logic [1:0]            coin_cnt;
  logic                  any_coin;
  logic                  sel_crown, sel_florin, sel_shilling;
  logic                  dispense_d, florin_d, florin_c_d, shilling_d, reject_d;

  change_selector u_change (
    .credit       (cState),
    .credit_next  (sel_next),
    .pay_crown    (sel_crown),
    .pay_florin   (sel_florin),
    .pay_shilling (sel_shilling)
  );

  // Coin pulse count and the value of a lone coin.
  always_comb begin
    coin_cnt = {1'b0, coin_shilling} + {1'b0, coin_florin} + {1'b0, coin_crown};
    any_coin = (coin_cnt != 2'd0);
    coin_val = '0;
    if (coin_shilling) coin_val = SHILLING_VAL;
    if (coin_florin)   coin_val = FLORIN_VAL;
    if (coin_crown)    coin_val = CROWN_VAL;
  end

  // Next state, next credit and next output pulses. Pulses are computed for
  // the cycle being entered so each output comes straight from a flop; this
  // is why the first payout is taken on the edge that enters CHANGE.
  always_comb begin
    state_d    = state_q;
    credit_d   = cState;
    dispense_d = 1'b0;
    florin_d   = 1'b0;
    florin_c_d = 1'b0;
    shilling_d = 1'b0;
    reject_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if ((state_q == ST_COLLECT) && (cState >= PRICE_C)) begin
          state_d    = ST_DISPENSE;
          credit_d   = cState - PRICE_C;
          dispense_d = 1'b1;
          reject_d   = any_coin;
        end else if ((state_q == ST_COLLECT) && cancel) begin
          state_d    = ST_CHANGE;
          credit_d   = sel_next;
          florin_d   = sel_florin;
          florin_c_d = sel_crown;
          shilling_d = sel_shilling;
          reject_d   = any_coin;
        end else if (coin_cnt == 2'd1) begin
          state_d  = ST_COLLECT;
          credit_d = cState + coin_val;
        end else begin
          reject_d = any_coin;
        end
      end
      ST_DISPENSE: begin
        state_d    = ST_CHANGE;
        credit_d   = sel_next;
        florin_d   = sel_florin;
        florin_c_d = sel_crown;
        shilling_d = sel_shilling;
        reject_d   = any_coin;
      end
      ST_CHANGE: begin
        reject_d = any_coin;
        if (cState == '0) begin
          state_d = ST_IDLE;
        end else begin
          credit_d   = sel_next;
          florin_d   = sel_florin;
          florin_c_d = sel_crown;
          shilling_d = sel_shilling;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, credit and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cState      <= '0;
      dispense    <= 1'b0;
      florin      <= 1'b0;
      florin_c    <= 1'b0;
      shilling    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cState      <= credit_d;
      dispense    <= dispense_d;
      florin      <= florin_d;
      florin_c    <= florin_c_d;
      shilling    <= shilling_d;
      coin_reject <= reject_d;
      busy        <= (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end
  end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Bench for coin_credit_fsm: two instances (PRICE 5 and 10), a per-cycle
// reference model that plans whole dispense/payout sequences arithmetically,
// and directed scenarios with literal expectations.
module tb_coin_credit_fsm;

  localparam int unsigned P0 = 5;
  localparam int unsigned P1 = 10;
`ifdef CROWN_CHANGE_EN
  localparam bit CROWN = 1'b1;
`else
  localparam bit CROWN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin_s[2], coin_f[2], coin_c[2], cancel_v[2];
  logic [3:0] cs[2];
  logic disp[2], fl[2], fc[2], sh[2], rej[2], bsy[2];

  always #5 clk = ~clk;

  coin_credit_fsm #(.PRICE(P0)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .coin_shilling(coin_s[0]), .coin_florin(coin_f[0]), .coin_crown(coin_c[0]),
    .cancel(cancel_v[0]), .cState(cs[0]), .dispense(disp[0]), .florin(fl[0]),
    .florin_c(fc[0]), .shilling(sh[0]), .coin_reject(rej[0]), .busy(bsy[0])
  );

  coin_credit_fsm #(.PRICE(P1)) u_dut10 (
    .clk(clk), .rst_n(rst_n),
    .coin_shilling(coin_s[1]), .coin_florin(coin_f[1]), .coin_crown(coin_c[1]),
    .cancel(cancel_v[1]), .cState(cs[1]), .dispense(disp[1]), .florin(fl[1]),
    .florin_c(fc[1]), .shilling(sh[1]), .coin_reject(rej[1]), .busy(bsy[1])
  );

  typedef struct packed {
    logic [3:0] cs;
    logic       disp;
    logic       fl;
    logic       fc;
    logic       sh;
    logic       busy;
  } rec_t;

  // Model: while a plan of future output cycles is pending the machine is
  // committed and rejects coins; otherwise it collects or starts a refund.
  rec_t        plan[2][16];
  int unsigned ph[2], pt[2];
  int unsigned m_credit[2];
  rec_t        exp_o[2];
  logic        exp_rej[2];

  int checks = 0;
  int errors = 0;

  function automatic int unsigned price_of(int i);
    return (i == 0) ? P0 : P1;
  endfunction

  task automatic push(int i, rec_t r);
    plan[i][pt[i]] = r;
    pt[i]++;
  endtask

  task automatic push_payout(int i, int unsigned amount);
    int unsigned r;
    rec_t e;
    r = amount;
    if (r == 0) begin
      e = '0; e.busy = 1'b1;
      push(i, e);
    end
    while (r > 0) begin
      e = '0; e.busy = 1'b1;
      if (CROWN && r >= 5) begin e.fc = 1'b1; r -= 5; end
      else if (r >= 2)     begin e.fl = 1'b1; r -= 2; end
      else                 begin e.sh = 1'b1; r -= 1; end
      e.cs = 4'(r);
      push(i, e);
    end
    e = '0;
    push(i, e);
  endtask

  task automatic model_step(int i);
    int unsigned n, v;
    rec_t e;
    n = int'(coin_s[i]) + int'(coin_f[i]) + int'(coin_c[i]);
    v = coin_s[i] ? 1 : (coin_f[i] ? 2 : 5);
    e = '0;
    exp_rej[i] = 1'b0;
    if (ph[i] != pt[i]) begin
      e = plan[i][ph[i]];
      ph[i]++;
      exp_rej[i] = (n > 0);
      m_credit[i] = e.cs;
    end else if (cancel_v[i] && m_credit[i] > 0) begin
      exp_rej[i] = (n > 0);
      ph[i] = 0; pt[i] = 0;
      push_payout(i, m_credit[i]);
      e = plan[i][0];
      ph[i] = 1;
      m_credit[i] = e.cs;
    end else if (n == 1) begin
      rec_t d;
      m_credit[i] += v;
      e.cs = 4'(m_credit[i]);
      if (m_credit[i] >= price_of(i)) begin
        ph[i] = 0; pt[i] = 0;
        d = '0; d.disp = 1'b1; d.busy = 1'b1;
        d.cs = 4'(m_credit[i] - price_of(i));
        push(i, d);
        push_payout(i, m_credit[i] - price_of(i));
      end
    end else begin
      exp_rej[i] = (n > 1);
      e.cs = 4'(m_credit[i]);
    end
    exp_o[i] = e;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; pt[i] = 0; m_credit[i] = 0;
        exp_o[i] = '0; exp_rej[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic chk(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, want);
    end
  endtask

  // Every cycle, mid-period: DUT outputs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.cState", i),      cs[i],   exp_o[i].cs);
      chk($sformatf("u%0d.dispense", i),    disp[i], exp_o[i].disp);
      chk($sformatf("u%0d.florin", i),      fl[i],   exp_o[i].fl);
      chk($sformatf("u%0d.florin_c", i),    fc[i],   exp_o[i].fc);
      chk($sformatf("u%0d.shilling", i),    sh[i],   exp_o[i].sh);
      chk($sformatf("u%0d.busy", i),        bsy[i],  exp_o[i].busy);
      chk($sformatf("u%0d.coin_reject", i), rej[i],  exp_rej[i]);
    end
  end

  task automatic drive(int i, logic s, logic f, logic c, logic cn);
    @(posedge clk); #1;
    coin_s[i] = s; coin_f[i] = f; coin_c[i] = c; cancel_v[i] = cn;
    @(posedge clk); #1;
    coin_s[i] = 1'b0; coin_f[i] = 1'b0; coin_c[i] = 1'b0; cancel_v[i] = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int unsigned t3_n;
  int unsigned t3_cs[5];
  int unsigned t3_kind[5];   // 1 florin, 2 crown, 3 shilling

  initial begin
    for (int i = 0; i < 2; i++) begin
      coin_s[i] = 1'b0; coin_f[i] = 1'b0; coin_c[i] = 1'b0; cancel_v[i] = 1'b0;
    end
`ifdef CROWN_CHANGE_EN
    t3_n = 3; t3_cs = '{4, 2, 0, 0, 0}; t3_kind = '{2, 1, 1, 0, 0};
`else
    t3_n = 5; t3_cs = '{7, 5, 3, 1, 0}; t3_kind = '{1, 1, 1, 1, 3};
`endif

    step(2);
    chk("rst cState", cs[0], 0);
    chk("rst busy", bsy[1], 0);
    rst_n = 1'b1;

    // PRICE 5: florin, florin, shilling -> exact price
    drive(0, 0, 1, 0, 0); chk("t1 cState a", cs[0], 2);
    drive(0, 0, 1, 0, 0); chk("t1 cState b", cs[0], 4);
    drive(0, 1, 0, 0, 0); chk("t1 cState c", cs[0], 5);
    step(1); chk("t1 dispense", disp[0], 1); chk("t1 cState d", cs[0], 0);
    step(1); chk("t1 no pay fl", fl[0], 0); chk("t1 no pay sh", sh[0], 0);
    chk("t1 dispense off", disp[0], 0);
    step(1); chk("t1 idle busy", bsy[0], 0);

    // PRICE 5: three florins -> one shilling change
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0); chk("t2 cState", cs[0], 6);
    step(1); chk("t2 dispense", disp[0], 1); chk("t2 remainder", cs[0], 1);
    step(1); chk("t2 shilling", sh[0], 1); chk("t2 cState0", cs[0], 0);
    step(1); chk("t2 busy low", bsy[0], 0); chk("t2 shilling off", sh[0], 0);

    // PRICE 10: crown, florin, florin = 9, then cancel
    drive(1, 0, 0, 1, 0); drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0); chk("t3 cState", cs[1], 9);
    drive(1, 0, 0, 0, 1);
    for (int k = 0; k < int'(t3_n); k++) begin
      chk("t3 refund cState", cs[1], t3_cs[k]);
      chk("t3 refund florin", fl[1], t3_kind[k] == 1);
      chk("t3 refund crown", fc[1], t3_kind[k] == 2);
      chk("t3 refund shilling", sh[1], t3_kind[k] == 3);
      chk("t3 no dispense", disp[1], 0);
      step(1);
    end
    chk("t3 busy low", bsy[1], 0);

    // PRICE 5: two coins at once with credit 3
    drive(0, 0, 1, 0, 0); drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0); chk("t4 reject", rej[0], 1); chk("t4 cState", cs[0], 3);
    step(1); chk("t4 reject off", rej[0], 0); chk("t4 cState hold", cs[0], 3);
    drive(0, 0, 0, 0, 1); chk("t4 refund florin", fl[0], 1);
    step(2);

    // PRICE 10: coin arriving during refund
    drive(1, 0, 1, 0, 0); drive(1, 0, 1, 0, 0); drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1); chk("t5 first florin", fl[1], 1); chk("t5 cState", cs[1], 4);
    coin_s[1] = 1'b1;
    step(1); coin_s[1] = 1'b0;
    chk("t5 reject", rej[1], 1); chk("t5 florin", fl[1], 1); chk("t5 cState b", cs[1], 2);
    step(2); chk("t5 busy low", bsy[1], 0);

    // PRICE 10: reset during refund with credit 3
    drive(1, 0, 0, 1, 0); drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1); step(1); chk("t6 cState pre", cs[1], 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst cState", cs[1], 0); chk("t6 rst busy", bsy[1], 0);
    chk("t6 rst florin", fl[1], 0); chk("t6 rst shilling", sh[1], 0);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    step(1); chk("t6 idle cState", cs[1], 0); chk("t6 idle busy", bsy[1], 0);
    drive(1, 1, 0, 0, 0); chk("t6 accepts", cs[1], 1);
    drive(1, 0, 0, 0, 1); chk("t6 refund sh", sh[1], 1);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
